// File: rtl/traffic_pkg.sv
// Shared types, default timing and the round-robin phase search for the
// multi-phase intersection controller.
//   phase_state_e : controller state encoding
//   DEF_*         : default timing/geometry values used by the top level
//   rr_next()     : next phase to serve given latched demand and current owner
package traffic_pkg;

   typedef enum logic [1:0] {
      ST_ALL_RED = 2'd0,
      ST_GREEN   = 2'd1,
      ST_YELLOW  = 2'd2
   } phase_state_e;

   localparam int DEF_NUM_PHASES = 4;
   localparam int DEF_CNT_W      = 8;
   localparam int DEF_MIN_GREEN  = 5;
   localparam int DEF_MAX_GREEN  = 15;
   localparam int DEF_YELLOW_T   = 3;
   localparam int DEF_ALLRED_T   = 2;

   // Widest demand vector rr_next() can search; callers size-cast into it.
   localparam int MAX_PHASES = 16;

   // First set bit of pend starting at active+1 and wrapping, with active
   // itself examined last. No demand at all falls back to phase 0.
   function automatic int unsigned rr_next(input logic [MAX_PHASES-1:0] pend,
                                           input int unsigned active,
                                           input int unsigned n);
      int unsigned idx;
      int unsigned result;
      logic        found;
      result = 0;
      found  = 1'b0;
      for (int k = 1; k <= MAX_PHASES; k++) begin
         idx = active + 32'(k);
         if (idx >= n) idx = idx - n;
         if ((32'(k) <= n) && !found && pend[idx[3:0]]) begin
            result = idx;
            found  = 1'b1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating dwell counter for the intersection controller.
//   clk   : clock
//   rst   : synchronous active-high reset, count -> 0
//   clr   : synchronous clear, asserted on the edge a state is entered
//   count : cycles spent in the current state, sticks at all ones
module phase_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst || clr)
         count <= '0;
      else if (count != {CNT_W{1'b1}})
         count <= count + 1'b1;
   end

endmodule

// File: rtl/multi_phase_traffic_ctrl.sv
// N-phase signalised-intersection controller with demand latching and
// round-robin service (idle phases are skipped).
//   clk, rst      : clock, synchronous active-high reset
//   req           : per-phase demand sensor (level or one-cycle pulse)
//   red/yellow/green : per-phase lamps, decoded from registered state
//   active_phase  : owner of green/yellow, or last owner during all-red
//   pending       : latched demand
// Build option TRAFFIC_PREEMPT_EN adds preempt/preempt_phase for
// emergency-vehicle preemption.
//
// state      | meaning
// ST_ALL_RED | clearance, every approach red; picks the next phase on exit
// ST_GREEN   | active_phase green; exits on min/max green rules
// ST_YELLOW  | active_phase yellow for YELLOW_T cycles
module multi_phase_traffic_ctrl
   import traffic_pkg::*;
#(
   parameter int NUM_PHASES = DEF_NUM_PHASES,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int MIN_GREEN  = DEF_MIN_GREEN,
   parameter int MAX_GREEN  = DEF_MAX_GREEN,
   parameter int YELLOW_T   = DEF_YELLOW_T,
   parameter int ALLRED_T   = DEF_ALLRED_T,
   localparam int PW        = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_PHASES-1:0] req,
`ifdef TRAFFIC_PREEMPT_EN
   input  logic                  preempt,
   input  logic [PW-1:0]         preempt_phase,
`endif
   output logic [NUM_PHASES-1:0] red,
   output logic [NUM_PHASES-1:0] yellow,
   output logic [NUM_PHASES-1:0] green,
   output logic [PW-1:0]         active_phase,
   output logic [NUM_PHASES-1:0] pending
);

   phase_state_e          state, state_nxt;
   logic [PW-1:0]         phase_nxt;
   logic [NUM_PHASES-1:0] pending_nxt;
   logic [NUM_PHASES-1:0] act_mask;
   logic [CNT_W-1:0]      timer;
   logic                  timer_clr;
   logic                  other_req;

   phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .clr   (timer_clr),
      .count (timer)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_ALL_RED;
         active_phase <= PW'(NUM_PHASES - 1);
         pending      <= '0;
      end else begin
         state        <= state_nxt;
         active_phase <= phase_nxt;
         pending      <= pending_nxt;
      end
   end

   assign act_mask  = NUM_PHASES'(1) << active_phase;
   assign other_req = |(pending & ~act_mask);

   always_comb begin
      state_nxt   = state;
      phase_nxt   = active_phase;
      pending_nxt = pending;

      case (state)
         ST_ALL_RED: begin
            if (timer == CNT_W'(ALLRED_T - 1)) begin
               state_nxt = ST_GREEN;
               phase_nxt = PW'(rr_next(MAX_PHASES'(pending), 32'(active_phase),
                                       NUM_PHASES));
`ifdef TRAFFIC_PREEMPT_EN
               if (preempt) phase_nxt = preempt_phase;
`endif
            end
         end
         ST_GREEN: begin
            // Own demand only extends green up to MAX_GREEN, and only
            // competing demand can end it at all.
            if (timer >= CNT_W'(MIN_GREEN - 1) && other_req &&
                (!req[active_phase] || timer >= CNT_W'(MAX_GREEN - 1)))
               state_nxt = ST_YELLOW;
`ifdef TRAFFIC_PREEMPT_EN
            if (preempt)
               state_nxt = (active_phase == preempt_phase) ? ST_GREEN : ST_YELLOW;
`endif
         end
         ST_YELLOW: begin
            if (timer == CNT_W'(YELLOW_T - 1))
               state_nxt = ST_ALL_RED;
         end
         default: state_nxt = ST_ALL_RED;
      endcase

      // Demand from the phase already holding green is meaningless.
      if (state == ST_GREEN)
         pending_nxt = pending | (req & ~act_mask);
      else
         pending_nxt = pending | req;

      // Served demand is dropped on green entry, overriding a same-cycle set.
      if (state_nxt == ST_GREEN && state != ST_GREEN)
         pending_nxt = pending_nxt & ~(NUM_PHASES'(1) << phase_nxt);
   end

   assign timer_clr = (state_nxt != state);

   always_comb begin
      green  = '0;
      yellow = '0;
      if (state == ST_GREEN)  green  = act_mask;
      if (state == ST_YELLOW) yellow = act_mask;
      red = ~(green | yellow);
   end

endmodule

// File: tb/tb_multi_phase_traffic_ctrl.sv
module tb_multi_phase_traffic_ctrl;

   localparam int NP = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [NP-1:0] req;
   logic [NP-1:0] red, yellow, green, pending;
   logic [1:0]    active_phase;
`ifdef TRAFFIC_PREEMPT_EN
   logic          preempt;
   logic [1:0]    preempt_phase;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int lamp_viol = 0;
   int g0_cnt    = 0;
   int bad_rest  = 0;

   always #5 clk = ~clk;

   multi_phase_traffic_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
`ifdef TRAFFIC_PREEMPT_EN
      .preempt      (preempt),
      .preempt_phase(preempt_phase),
`endif
      .red          (red),
      .yellow       (yellow),
      .green        (green),
      .active_phase (active_phase),
      .pending      (pending)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Each phase must show exactly one lamp, and at most one phase non-red.
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NP; i++)
            if ((32'(red[i]) + 32'(yellow[i]) + 32'(green[i])) != 1) lamp_viol++;
         if ($countones(~red) > 1) lamp_viol++;
         if (green[0]) g0_cnt++;
      end
   end

   initial begin
      rst = 1'b1;
      req = '0;
`ifdef TRAFFIC_PREEMPT_EN
      preempt       = 1'b0;
      preempt_phase = '0;
`endif
      tick(2);
      chk("rst_red",     32'(red), 32'hF);
      chk("rst_green",   32'(green), 32'h0);
      chk("rst_yellow",  32'(yellow), 32'h0);
      chk("rst_active",  32'(active_phase), 32'd3);
      chk("rst_pending", 32'(pending), 32'h0);

      // Power-up: two all-red cycles then main road, resting with no demand.
      rst = 1'b0;
      tick(1);
      chk("pwr_allred", 32'(red), 32'hF);
      tick(1);
      chk("pwr_green0", 32'(green), 32'h1);
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (green != 4'b0001 || yellow != 4'b0000) bad_rest++;
      end
      chk("rest_100", 32'(bad_rest), 32'd0);

      // Single pulse on phase 2 from fresh phase-0 green.
      rst = 1'b1; tick(1); rst = 1'b0; tick(2);
      chk("p2_start_g0", 32'(green), 32'h1);
      req = 4'b0100; tick(1); req = '0;
      chk("p2_pend_set", 32'(pending), 32'h4);
      tick(3);
      chk("p2_min_green", 32'(green), 32'h1);
      tick(1);
      chk("p2_yellow", 32'(yellow), 32'h1);
      tick(2);
      chk("p2_yellow_end", 32'(yellow), 32'h1);
      tick(1);
      chk("p2_allred", 32'(red), 32'hF);
      chk("p2_allred_act", 32'(active_phase), 32'd0);
      tick(1);
      chk("p2_allred2", 32'(red), 32'hF);
      tick(1);
      chk("p2_green2", 32'(green), 32'h4);
      chk("p2_active", 32'(active_phase), 32'd2);
      chk("p2_pend_clr", 32'(pending), 32'h0);

      // From phase 2, demand on 1 and 3: round-robin serves 3 then 1.
      g0_cnt = 0;
      req = 4'b1010; tick(1); req = '0;
      chk("rr_pend", 32'(pending), 32'hA);
      tick(9);
      chk("rr_green3", 32'(green), 32'h8);
      chk("rr_act3", 32'(active_phase), 32'd3);
      chk("rr_pend1", 32'(pending), 32'h2);
      tick(10);
      chk("rr_green1", 32'(green), 32'h2);
      chk("rr_act1", 32'(active_phase), 32'd1);
      chk("rr_pend0", 32'(pending), 32'h0);
      chk("rr_no_g0", 32'(g0_cnt), 32'd0);

      // Main road held by its own demand: max green of 15 cycles.
      rst = 1'b1; tick(1); rst = 1'b0; tick(2);
      chk("mx_start_g0", 32'(green), 32'h1);
      req = 4'b0011; tick(1); req = 4'b0001;
      tick(13);
      chk("mx_green_t14", 32'(green), 32'h1);
      chk("mx_own_ignored", 32'(pending), 32'h2);
      tick(1);
      chk("mx_yellow", 32'(yellow), 32'h1);
      tick(5);
      chk("mx_green1", 32'(green), 32'h2);
      chk("mx_pend0", 32'(pending), 32'h1);
      req = '0;

      // Reset during phase-1 yellow, timer=1.
      tick(5);
      tick(1);
      chk("rs_yellow1", 32'(yellow), 32'h2);
      rst = 1'b1; tick(1);
      chk("rs_red", 32'(red), 32'hF);
      chk("rs_pending", 32'(pending), 32'h0);
      chk("rs_active", 32'(active_phase), 32'd3);
      rst = 1'b0;
      tick(1);
      chk("rs_allred", 32'(red), 32'hF);
      tick(1);
      chk("rs_green0", 32'(green), 32'h1);

`ifdef TRAFFIC_PREEMPT_EN
      rst = 1'b1; tick(1); rst = 1'b0; tick(2);
      tick(1);
      req = 4'b0010; preempt = 1'b1; preempt_phase = 2'd3;
      tick(1); req = '0;
      chk("pe_yellow", 32'(yellow), 32'h1);
      tick(3);
      chk("pe_allred", 32'(red), 32'hF);
      tick(2);
      chk("pe_green3", 32'(green), 32'h8);
      tick(20);
      chk("pe_hold3", 32'(green), 32'h8);
      chk("pe_pend1", 32'(pending), 32'h2);
      preempt = 1'b0;
      tick(1);
      chk("pe_release", 32'(yellow), 32'h8);
`endif

      chk("lamp_excl", 32'(lamp_viol), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_phase_traffic_ctrl.md
Name: multi_phase_traffic_ctrl

Overview:
- N-phase signalised-intersection controller; generalises the two-road main/side controller to NUM_PHASES approaches.
- Integrates its own dwell timer; per-phase demand latching; round-robin service with phase skipping.
- Provides min/max green, yellow and all-red clearance intervals.
- Drives per-phase red/yellow/green lamp vectors; sits directly under the intersection top level.

Parameters:
NUM_PHASES, 4, number of approaches/phases (>=2); phase 0 is the main road
CNT_W, 8, dwell-timer width; must hold MAX_GREEN
MIN_GREEN, 5, minimum green cycles (>=1)
MAX_GREEN, 15, maximum green cycles when other demand is pending (>=MIN_GREEN)
YELLOW_T, 3, yellow cycles (>=1)
ALLRED_T, 2, all-red clearance cycles (>=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
req  input  NUM_PHASES  per-phase vehicle/demand sensor, level or single-cycle pulse
red  output  NUM_PHASES  red lamp per phase
yellow  output  NUM_PHASES  yellow lamp per phase
green  output  NUM_PHASES  green lamp per phase
active_phase  output  $clog2(NUM_PHASES)  phase currently owning green/yellow, or last owner during all-red
pending  output  NUM_PHASES  latched demand register (debug/visibility)

Behaviour:
- Reset is synchronous, active-high, on clk: state=ALL_RED, timer=0, active_phase=NUM_PHASES-1, pending=0; outputs red=all 1, yellow=0, green=0.
- Lamps are a pure decode of registered state/active_phase:
  - exactly one lamp per phase is lit;
  - only active_phase can be green or yellow;
  - all other phases are red.
- Timer: cleared to 0 on every state entry, +1 per cycle, saturates at 2^CNT_W-1. A state of duration D exits on the edge where timer==D-1.
- Demand latching:
  - pending[i] is set when req[i]=1.
  - Exception: req[i] for active_phase during GREEN is ignored.
  - pending[i] clears on the cycle phase i enters GREEN. Set and clear in the same cycle: clear wins.
  - Define other_req = |(pending with the active bit masked).
- GREEN exits to YELLOW when timer>=MIN_GREEN-1 && other_req && (!req[active_phase] || timer>=MAX_GREEN-1).
  - With no other demand the phase rests in green indefinitely, regardless of MAX_GREEN.
- YELLOW: after YELLOW_T cycles -> ALL_RED.
- ALL_RED: after ALL_RED_T cycles -> GREEN on the next phase.
  - Next phase = first set bit of pending, searching active_phase+1 upward with wrap, active_phase itself last.
  - If pending=0, next phase = 0 (main road default).
  - active_phase updates on entry to GREEN.
- After reset: green[0] asserts exactly ALLRED_T cycles after the first cycle with rst=0, assuming no demand.
- Reset mid-operation (any state) forces the reset values on the next edge; all latched demand is discarded.
- Green-to-green with no yellow/all-red between is illegal; no two phases are ever simultaneously non-red.

Optional Feature:
- Macro: TRAFFIC_PREEMPT_EN.
- When defined, adds ports `preempt` (input 1) and `preempt_phase` (input $clog2(NUM_PHASES)) for emergency-vehicle preemption. While preempt=1:
  - GREEN on a phase != preempt_phase goes to YELLOW on the next edge, ignoring MIN_GREEN.
  - ALL_RED selects preempt_phase, ignoring round-robin.
  - GREEN on preempt_phase holds regardless of other demand.
  - YELLOW and ALL_RED durations are never shortened.
  - Pending demand keeps latching. On preempt deassertion, normal rules resume from the current state.
- When undefined: the ports are absent and behaviour is exactly as above.

Decomposition:
- Package traffic_pkg holds:
  - typedef enum phase_state_e {ST_ALL_RED, ST_GREEN, ST_YELLOW};
  - a default-timing localparam set;
  - a function rr_next(pending, active) implementing the wrap search.
- Sub-module phase_timer (clk, rst, clr, count out, CNT_W parameter) provides the saturating dwell counter; it replaces the old free-standing timer.

Test Plan:
- Reset released, req=0 -> red=4'b1111 for 2 cycles, then green=4'b0001; held for 100 cycles with no yellow.
- Phase 0 green at timer=0, req[2] pulsed 1 cycle -> phase 0 green 5 cycles, yellow 3, all-red 2, green=4'b0100; pending[2] clears at green entry.
- req[0] held high, req[1] pulsed -> phase 0 green exactly 15 cycles, then yellow 3, all-red 2, green[1].
- Phase 2 green, req[1] and req[3] pulsed -> order serviced is 3 then 1; phase 0 never green; no two phases non-red simultaneously.
- rst asserted during phase 1 yellow timer=1 -> next edge red=all 1, pending=0, active_phase=3; green[0] 2 cycles after release.
- TRAFFIC_PREEMPT_EN: phase 0 green timer=1, preempt=1, preempt_phase=3 -> yellow next edge, 3 yellow, 2 all-red, green[3] held while preempt=1 despite pending[1].
